dtt_decoder: RTL and testbench

//   Time-to-first-spike (TTFS) decoder, the receive side of the dtt encoder.

---
 rtl/dtt_decoder.sv | 120 ++++++++++++
 tb/tb_dtt_decoder.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/dtt_decoder.sv
// Time-to-first-spike decoder: opens a window on start, records per channel the cycle count of
// the first spike, and returns the values as one frame over a valid/ready handshake.
module dtt_decoder #(
  parameter int NCH       = 4,
  parameter int DTT_WIDTH = 5
) (
  input  logic                     CLK,
  input  logic                     RES,
  input  logic                     start,
  input  logic [NCH-1:0]           spike_in,
  output logic                     busy,
  output logic                     valid_out,
  input  logic                     ready_in,
  output logic [NCH*DTT_WIDTH-1:0] value_out,
  output logic [NCH-1:0]           fired_out
);

  localparam logic [DTT_WIDTH-1:0] MAXT = '1;

  typedef enum logic [1:0] {IDLE, CAPTURE, DONE} state_t;

  state_t                   state, state_nx;
  logic [DTT_WIDTH-1:0]     cnt;
  logic [NCH-1:0]           mask;
  logic [NCH*DTT_WIDTH-1:0] vals;

  logic [NCH-1:0]           mask_cap;
  logic [NCH*DTT_WIDTH-1:0] vals_cap;
  logic                     exit_cond;
  logic                     load;
  logic                     capture;
  logic                     done_entry;

  // Captures on the exit edge must be folded into the frame, so the
  // merged mask/values are built combinationally and reused below.
  always_comb begin
    mask_cap = mask | spike_in;
    vals_cap = vals;
    for (int i = 0; i < NCH; i++) begin
      if (spike_in[i] && !mask[i]) begin
        vals_cap[i*DTT_WIDTH +: DTT_WIDTH] = cnt;
      end
    end
    exit_cond = (&mask_cap) || (cnt == MAXT);
  end

  always_ff @(posedge CLK) begin
    if (RES) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    busy       = 1'b0;
    valid_out  = 1'b0;
    load       = 1'b0;
    capture    = 1'b0;
    done_entry = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = CAPTURE;
          load     = 1'b1;
        end
      end
      CAPTURE: begin
        busy = 1'b1;
        // Restart wins over exit; spikes on the restart edge are dropped.
        if (start) begin
          load = 1'b1;
        end else begin
          capture = 1'b1;
          if (exit_cond) begin
            state_nx   = DONE;
            done_entry = 1'b1;
          end
        end
      end
      DONE: begin
        valid_out = 1'b1;
        if (ready_in) begin
          if (start) begin
            state_nx = CAPTURE;
            load     = 1'b1;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RES) begin
      cnt       <= '0;
      mask      <= '0;
      vals      <= '0;
      value_out <= '0;
      fired_out <= '0;
    end else if (load) begin
      cnt  <= DTT_WIDTH'(1);
      mask <= '0;
      vals <= '0;
    end else if (capture) begin
      mask <= mask_cap;
      vals <= vals_cap;
      if (done_entry) begin
        value_out <= vals_cap;
        fired_out <= mask_cap;
      end else begin
        cnt <= cnt + DTT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_dtt_decoder.sv
// Directed bench for dtt_decoder: a driver replays per-cycle start/spike tables and pushes
// expected frames; a monitor pops and compares on every valid/ready transfer.
module tb_dtt_decoder;

  localparam int NCH = 4;
  localparam int W   = 5;
  localparam int TBL = 80;

  logic             CLK = 1'b0;
  logic             RES;
  logic             start;
  logic [NCH-1:0]   spike_in;
  logic             busy;
  logic             valid_out;
  logic             ready_in;
  logic [NCH*W-1:0] value_out;
  logic [NCH-1:0]   fired_out;

  typedef struct packed {
    logic [NCH*W-1:0] val;
    logic [NCH-1:0]   fired;
  } frame_t;

  frame_t         exp_q[$];
  int             errors = 0;
  int             checks = 0;
  logic [NCH-1:0] spk_tbl [TBL];
  logic           st_tbl  [TBL];

  dtt_decoder #(.NCH(NCH), .DTT_WIDTH(W)) dut (
    .CLK       (CLK),
    .RES       (RES),
    .start     (start),
    .spike_in  (spike_in),
    .busy      (busy),
    .valid_out (valid_out),
    .ready_in  (ready_in),
    .value_out (value_out),
    .fired_out (fired_out)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_tbl();
    for (int k = 0; k < TBL; k++) begin
      spk_tbl[k] = '0;
      st_tbl[k]  = 1'b0;
    end
  endtask

  // Encoder model: start at base, channel with value v spikes in the cycle sampled at cnt==v.
  task automatic enc(input int base, input int v0, input int v1, input int v2, input int v3);
    int v[NCH];
    v[0] = v0; v[1] = v1; v[2] = v2; v[3] = v3;
    st_tbl[base] = 1'b1;
    for (int i = 0; i < NCH; i++) begin
      if (v[i] != 0) spk_tbl[base + v[i]][i] = 1'b1;
    end
  endtask

  task automatic push_exp(input int v0, input int v1, input int v2, input int v3,
                          input logic [NCH-1:0] f);
    frame_t fr;
    fr.val   = {W'(v3), W'(v2), W'(v1), W'(v0)};
    fr.fired = f;
    exp_q.push_back(fr);
  endtask

  // Row k of the tables is sampled on edge k after the first start; latency is
  // the first row index at which valid_out is already visible.
  task automatic play(input int n, input logic rdy, input int exp_lat, input string nm);
    int lat;
    lat = -1;
    for (int k = 0; k < n; k++) begin
      step();
      if (k > 0 && lat < 0 && valid_out) lat = k;
      if (k == 1) chk({nm, "_busy"}, 32'(busy), 32'd1);
      start    = st_tbl[k];
      spike_in = spk_tbl[k];
      if (k == 0) ready_in = rdy;
    end
    step();
    start    = 1'b0;
    spike_in = '0;
    if (exp_lat >= 0) chk({nm, "_latency"}, lat, exp_lat);
  endtask

  always @(negedge CLK) begin
    if (!RES && valid_out && ready_in) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_frame: got value %0h fired %0h expected no frame",
                 value_out, fired_out);
      end else begin
        frame_t fr;
        fr = exp_q.pop_front();
        chk("frame_value", 32'(value_out), 32'(fr.val));
        chk("frame_fired", 32'(fired_out), 32'(fr.fired));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    RES      = 1'b1;
    start    = 1'b0;
    spike_in = '0;
    ready_in = 1'b0;
    repeat (3) step();
    RES = 1'b0;
    chk("rst_busy",  32'(busy),      32'd0);
    chk("rst_valid", 32'(valid_out), 32'd0);
    chk("rst_value", 32'(value_out), 32'd0);
    chk("rst_fired", 32'(fired_out), 32'd0);

    // Round trip
    clear_tbl();
    enc(0, 3, 1, 7, 31);
    push_exp(3, 1, 7, 31, 4'b1111);
    play(34, 1'b1, 32, "roundtrip");

    // Silent channel 1 forces the full window
    clear_tbl();
    enc(0, 5, 0, 2, 9);
    push_exp(5, 0, 2, 9, 4'b1101);
    play(34, 1'b1, 32, "silent");

    // Repeat spikes: first spike only
    clear_tbl();
    enc(0, 4, 10, 12, 15);
    spk_tbl[6][0]  = 1'b1;
    spk_tbl[8][0]  = 1'b1;
    spk_tbl[13][2] = 1'b1;
    push_exp(4, 10, 12, 15, 4'b1111);
    play(20, 1'b1, 16, "repeat");

    // Restart at cnt=10; a spike on the restart edge must be dropped
    clear_tbl();
    enc(0, 5, 8, 20, 25);
    enc(10, 2, 2, 2, 2);
    spk_tbl[10][3] = 1'b1;
    push_exp(2, 2, 2, 2, 4'b1111);
    play(16, 1'b1, 13, "restart");

    // Backpressure: frame held, start and spikes ignored in DONE
    clear_tbl();
    enc(0, 1, 2, 3, 4);
    push_exp(1, 2, 3, 4, 4'b1111);
    play(6, 1'b0, 5, "bp");
    for (int j = 0; j < 20; j++) begin
      chk("bp_valid", 32'(valid_out), 32'd1);
      chk("bp_busy",  32'(busy),      32'd0);
      chk("bp_value", 32'(value_out), {12'd0, 5'd4, 5'd3, 5'd2, 5'd1});
      chk("bp_fired", 32'(fired_out), 32'hF);
      start    = (j % 4 == 0);
      spike_in = 4'(j);
      step();
    end
    start    = 1'b0;
    spike_in = '0;
    chk("bp_hold_valid", 32'(valid_out), 32'd1);

    // Transfer and start on the same edge opens a new window directly
    clear_tbl();
    enc(0, 6, 6, 6, 6);
    push_exp(6, 6, 6, 6, 4'b1111);
    play(10, 1'b1, 7, "bp_restart");

    // Reset at cnt=6 throws away the window and the held frame
    clear_tbl();
    enc(0, 10, 10, 10, 10);
    play(6, 1'b1, -1, "rst_mid");
    RES = 1'b1;
    step();
    RES = 1'b0;
    chk("rstmid_busy",  32'(busy),      32'd0);
    chk("rstmid_valid", 32'(valid_out), 32'd0);
    chk("rstmid_value", 32'(value_out), 32'd0);
    chk("rstmid_fired", 32'(fired_out), 32'd0);

    clear_tbl();
    enc(0, 3, 4, 5, 6);
    push_exp(3, 4, 5, 6, 4'b1111);
    play(10, 1'b1, 7, "post_rst");

    repeat (3) step();
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
